// File: rtl/fft_stream_out_if.sv
// Handshake bundle for the FFT frame unloader: a wide frame-capture port on
// the input side and a one-word-per-cycle valid/ready stream on the output.
interface fft_stream_out_if #(
    parameter int bits = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [32*2*bits-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*bits-1:0]       out_data;
    logic [4:0]              out_index;
    logic                    out_last;

    // Unloader side: accepts frames, produces the word stream.
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );

    // Environment side: offers frames, consumes the word stream.
    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/fft_stream_out.sv
// Output unloader for the 32-point FFT: captures a whole complex frame in one
// handshake, then streams it one word per cycle in natural or bit-reversed
// order. Data is passed through bit-exact; fix_bit only documents the format.
module fft_stream_out #(
    parameter int fix_bit = 7,
    parameter int bits    = 16,
    parameter bit BIT_REV = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    fft_stream_out_if.master bus,
    output logic [15:0]      frame_cnt,
    output logic             drop_err
);
    localparam int W = 2 * bits;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [4:0]     idx, idx_nxt;
    logic [W-1:0]   buffer [32];
    logic [4:0]     rd_addr;
    logic           capture;
    logic           beat;
    logic           final_beat;

    if (fix_bit < 0 || fix_bit >= bits) begin : g_bad_format
        $error("fix_bit must lie within one half-word");
    end

    function automatic logic [4:0] bitrev5(input logic [4:0] k);
        return {k[0], k[1], k[2], k[3], k[4]};
    endfunction

    // The last accepted beat frees the buffer, so a new frame may land on that same edge.
    assign bus.in_ready = reset & ((state == IDLE) |
                                   ((state == STREAM) & (idx == 5'd31) & bus.out_ready));
    assign capture      = bus.in_valid & bus.in_ready;
    assign beat         = (state == STREAM) & bus.out_ready;
    assign final_beat   = beat & (idx == 5'd31);

    // Outputs come from state, idx and the buffer only (no path from out_ready).
    assign rd_addr       = BIT_REV ? bitrev5(idx) : idx;
    assign bus.out_valid = (state == STREAM);
    assign bus.out_data  = buffer[rd_addr];
    assign bus.out_index = idx;
    assign bus.out_last  = (state == STREAM) & (idx == 5'd31);

    // Next-state and read-index logic; capture takes priority over returning to idle.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (capture) begin
            state_nxt = STREAM;
            idx_nxt   = 5'd0;
        end else if (final_beat) begin
            state_nxt = IDLE;
            idx_nxt   = 5'd0;
        end else if (beat) begin
            idx_nxt = idx + 5'd1;
        end
    end

    // State and read-index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= 5'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Frame buffer: all 32 words written at once on a capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) buffer[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < 32; i++) buffer[i] <= bus.in_data[i*W +: W];
        end
    end

    // Completed-frame counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= 16'd0;
        end else if (final_beat) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Sticky flag for frames offered while the buffer was busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_err <= 1'b0;
        end else if (bus.in_valid & ~bus.in_ready) begin
            drop_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_stream_out.sv
// Bench for fft_stream_out: a natural-order and a bit-reversed instance share
// clock and reset; expected words are queued when a frame is offered and
// popped on each output handshake.
module tb_fft_stream_out;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] frame_cnt0, frame_cnt1;
    logic        drop_err0, drop_err1;

    fft_stream_out_if #(.bits(16)) bus0 ();
    fft_stream_out_if #(.bits(16)) bus1 ();

    fft_stream_out #(.fix_bit(7), .bits(16), .BIT_REV(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .frame_cnt(frame_cnt0), .drop_err(drop_err0)
    );
    fft_stream_out #(.fix_bit(7), .bits(16), .BIT_REV(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .frame_cnt(frame_cnt1), .drop_err(drop_err1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  i;
        logic        l;
    } exp_t;

    exp_t          sb[$];
    int            vectors    = 0;
    int            miscompares = 0;
    int            exp_frames0 = 0;
    int            exp_frames1 = 0;
    logic [1023:0] fr;

    function automatic logic [1023:0] make_frame(input int re0, input int im0);
        logic [1023:0] f;
        for (int i = 0; i < 32; i++) f[i*32 +: 32] = {16'(re0 + i), 16'(im0 + i)};
        return f;
    endfunction

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) if (k[b]) r |= 1 << (4 - b);
        return r;
    endfunction

    task automatic push_frame(input logic [1023:0] f, input bit rev);
        exp_t e;
        int   src;
        for (int k = 0; k < 32; k++) begin
            src = rev ? brev(k) : k;
            e.d = f[src*32 +: 32];
            e.i = 5'(k);
            e.l = (k == 31);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus0.out_valid); end
        vectors++; if (bus0.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bus0.in_ready); end
        vectors++; if (bus0.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b want 0", bus0.out_last); end
        vectors++; if (bus0.out_index !== 5'd0) begin miscompares++; $display("FAIL reset_out_index got %0d want 0", bus0.out_index); end
        vectors++; if (bus0.out_data !== 32'd0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", bus0.out_data); end
        vectors++; if (frame_cnt0 !== 16'd0) begin miscompares++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt0); end
        vectors++; if (drop_err0 !== 1'b0) begin miscompares++; $display("FAIL reset_drop_err got %b want 0", drop_err0); end
        vectors++; if (bus1.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid_rev got %b want 0", bus1.out_valid); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", bus0.in_ready); end
        vectors++; if (bus1.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready_rev got %b want 1", bus1.in_ready); end
    endtask

    task automatic test_natural();
        exp_t e;
        int   got = 0;
        int   cyc = 0;
        @(posedge clk); #1;
        fr = make_frame(0, 100);
        bus0.in_data = fr; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
        push_frame(fr, 1'b0);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        while (got < 32 && cyc < 100) begin
            @(negedge clk);
            vectors++; if (bus0.out_valid !== 1'b1) begin miscompares++; $display("FAIL natural_bubble got out_valid=%b want 1 at beat %0d", bus0.out_valid, got); end
            if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (bus0.out_data !== e.d || bus0.out_index !== e.i || bus0.out_last !== e.l) begin
                    miscompares++;
                    $display("FAIL natural_beat got d=%h k=%0d last=%b want d=%h k=%0d last=%b", bus0.out_data, bus0.out_index, bus0.out_last, e.d, e.i, e.l);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (got < 32) begin miscompares++; $display("FAIL natural_timeout got %0d beats want 32", got); end
        exp_frames0++;
        @(negedge clk);
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL natural_idle got out_valid=%b want 0", bus0.out_valid); end
        vectors++; if (frame_cnt0 !== 16'(exp_frames0)) begin miscompares++; $display("FAIL natural_frame_cnt got %0d want %0d", frame_cnt0, exp_frames0); end
    endtask

    task automatic test_bitrev();
        exp_t e;
        int   got = 0;
        int   cyc = 0;
        sb.delete();
        @(posedge clk); #1;
        fr = make_frame(0, 100);
        bus1.in_data = fr; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        push_frame(fr, 1'b1);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        while (got < 32 && cyc < 100) begin
            @(negedge clk);
            vectors++; if (bus1.out_valid !== 1'b1) begin miscompares++; $display("FAIL bitrev_bubble got out_valid=%b want 1 at beat %0d", bus1.out_valid, got); end
            if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (bus1.out_data !== e.d || bus1.out_index !== e.i || bus1.out_last !== e.l) begin
                    miscompares++;
                    $display("FAIL bitrev_beat got d=%h k=%0d last=%b want d=%h k=%0d last=%b", bus1.out_data, bus1.out_index, bus1.out_last, e.d, e.i, e.l);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (got < 32) begin miscompares++; $display("FAIL bitrev_timeout got %0d beats want 32", got); end
        exp_frames1++;
        @(negedge clk);
        vectors++; if (bus1.out_valid !== 1'b0) begin miscompares++; $display("FAIL bitrev_idle got out_valid=%b want 0", bus1.out_valid); end
        vectors++; if (frame_cnt1 !== 16'(exp_frames1)) begin miscompares++; $display("FAIL bitrev_frame_cnt got %0d want %0d", frame_cnt1, exp_frames1); end
    endtask

    task automatic test_stall();
        exp_t        e;
        int          got = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] held_d = '0;
        logic [4:0]  held_i = '0;
        sb.delete();
        @(posedge clk); #1;
        fr = make_frame(50, 150);
        bus0.in_data = fr; bus0.in_valid = 1'b1; bus0.out_ready = 1'($urandom_range(0, 1));
        push_frame(fr, 1'b0);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        while (got < 32 && cyc < 400) begin
            @(negedge clk);
            if (stalled) begin
                vectors++;
                if (bus0.out_data !== held_d || bus0.out_index !== held_i) begin
                    miscompares++;
                    $display("FAIL stall_hold got d=%h k=%0d want d=%h k=%0d", bus0.out_data, bus0.out_index, held_d, held_i);
                end
            end
            if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (bus0.out_data !== e.d || bus0.out_index !== e.i || bus0.out_last !== e.l) begin
                    miscompares++;
                    $display("FAIL stall_beat got d=%h k=%0d last=%b want d=%h k=%0d last=%b", bus0.out_data, bus0.out_index, bus0.out_last, e.d, e.i, e.l);
                end
                got++;
                stalled = 1'b0;
            end else if (bus0.out_valid === 1'b1) begin
                stalled = 1'b1;
                held_d  = bus0.out_data;
                held_i  = bus0.out_index;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            bus0.out_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        if (got < 32) begin miscompares++; $display("FAIL stall_timeout got %0d beats want 32", got); end
        exp_frames0++;
        bus0.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_extra_word got out_valid=%b want 0", bus0.out_valid); end
        end
        vectors++; if (frame_cnt0 !== 16'(exp_frames0)) begin miscompares++; $display("FAIL stall_frame_cnt got %0d want %0d", frame_cnt0, exp_frames0); end
        @(posedge clk); #1;
    endtask

    task automatic test_drop();
        exp_t e;
        int   got = 0;
        int   cyc = 0;
        sb.delete();
        fr = make_frame(7, 70);
        bus0.in_data = fr; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
        push_frame(fr, 1'b0);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (drop_err0 !== 1'b0) begin miscompares++; $display("FAIL drop_before got %b want 0", drop_err0); end
        while (got < 32 && cyc < 100) begin
            if (cyc > 0) @(negedge clk);
            if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (bus0.out_data !== e.d || bus0.out_index !== e.i || bus0.out_last !== e.l) begin
                    miscompares++;
                    $display("FAIL drop_beat got d=%h k=%0d last=%b want d=%h k=%0d last=%b", bus0.out_data, bus0.out_index, bus0.out_last, e.d, e.i, e.l);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (got == 10) begin
                bus0.in_data  = make_frame(900, 1900);
                bus0.in_valid = 1'b1;
            end else begin
                bus0.in_valid = 1'b0;
            end
        end
        if (got < 32) begin miscompares++; $display("FAIL drop_timeout got %0d beats want 32", got); end
        exp_frames0++;
        vectors++; if (drop_err0 !== 1'b1) begin miscompares++; $display("FAIL drop_flag got %b want 1", drop_err0); end
        repeat (3) begin
            @(negedge clk);
            vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_recaptured got out_valid=%b want 0", bus0.out_valid); end
        end
        vectors++; if (frame_cnt0 !== 16'(exp_frames0)) begin miscompares++; $display("FAIL drop_frame_cnt got %0d want %0d", frame_cnt0, exp_frames0); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   got = 0;
        int   cyc = 0;
        sb.delete();
        fr = make_frame(0, 100);
        bus0.in_data = fr; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
        push_frame(fr, 1'b0);
        fr = make_frame(200, 300);
        push_frame(fr, 1'b0);
        @(posedge clk); #1;
        bus0.in_data = fr;
        while (got < 64 && cyc < 200) begin
            @(negedge clk);
            vectors++; if (bus0.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_bubble got out_valid=%b want 1 at beat %0d", bus0.out_valid, got); end
            if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (bus0.out_data !== e.d || bus0.out_index !== e.i || bus0.out_last !== e.l) begin
                    miscompares++;
                    $display("FAIL b2b_beat got d=%h k=%0d last=%b want d=%h k=%0d last=%b", bus0.out_data, bus0.out_index, bus0.out_last, e.d, e.i, e.l);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (got == 32) bus0.in_valid = 1'b0;
        end
        if (got < 64) begin miscompares++; $display("FAIL b2b_timeout got %0d beats want 64", got); end
        vectors++; if (cyc !== 64) begin miscompares++; $display("FAIL b2b_cycles got %0d cycles want 64", cyc); end
        exp_frames0 += 2;
        @(negedge clk);
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got out_valid=%b want 0", bus0.out_valid); end
        vectors++; if (frame_cnt0 !== 16'(exp_frames0)) begin miscompares++; $display("FAIL b2b_frame_cnt got %0d want %0d", frame_cnt0, exp_frames0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   got = 0;
        int   cyc = 0;
        sb.delete();
        fr = make_frame(33, 66);
        bus0.in_data = fr; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
        push_frame(fr, 1'b0);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        while (got < 5 && cyc < 50) begin
            @(negedge clk);
            if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (bus0.out_data !== e.d || bus0.out_index !== e.i) begin
                    miscompares++;
                    $display("FAIL midrst_beat got d=%h k=%0d want d=%h k=%0d", bus0.out_data, bus0.out_index, e.d, e.i);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (got < 5) begin miscompares++; $display("FAIL midrst_timeout got %0d beats want 5", got); end
        vectors++; if (bus0.out_index !== 5'd5) begin miscompares++; $display("FAIL midrst_position got k=%0d want 5", bus0.out_index); end
        reset = 1'b0;
        #1;
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_async_valid got %b want 0", bus0.out_valid); end
        vectors++; if (bus0.in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready got %b want 0", bus0.in_ready); end
        sb.delete();
        exp_frames0 = 0;
        exp_frames1 = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_release_ready got %b want 1", bus0.in_ready); end
        vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_release_valid got %b want 0", bus0.out_valid); end
        vectors++; if (frame_cnt0 !== 16'(exp_frames0)) begin miscompares++; $display("FAIL midrst_frame_cnt got %0d want %0d", frame_cnt0, exp_frames0); end
        vectors++; if (drop_err0 !== 1'b0) begin miscompares++; $display("FAIL midrst_drop_err got %b want 0", drop_err0); end
        vectors++; if (bus0.out_data !== 32'd0) begin miscompares++; $display("FAIL midrst_buffer got %h want 0", bus0.out_data); end
        vectors++; if (frame_cnt1 !== 16'(exp_frames1)) begin miscompares++; $display("FAIL midrst_frame_cnt_rev got %0d want %0d", frame_cnt1, exp_frames1); end
    endtask

    initial begin
        reset          = 1'b0;
        bus0.in_valid  = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        bus1.in_valid  = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        test_reset();
        test_natural();
        test_bitrev();
        test_stall();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
